eth_phy_10g_tx_gearbox: RTL

- 64b/66b-to-64-bit TX gearbox directly downstream of the 10G PHY TX (encoder + scrambler) stage.
- Accepts one 66-bit block (2-bit sync header + 64-bit scrambled payload) per accepted cycle and emits a continuous 64-bit word stream to a fixed-width transceiver.
- Over every 33-cycle sequence it consumes 32 blocks and asserts a one-cycle pause that upstream must honour.
- Also monitors sync-header validity.

---
 rtl/eth_phy_10g_pkg.sv | 9 +
 rtl/eth_phy_10g_hdr_check.sv | 44 ++++
 rtl/eth_phy_10g_tx_gearbox.sv | 87 ++++++++
 3 files changed

// File: rtl/eth_phy_10g_pkg.sv
// Shared constants for the 10G PHY TX path: sync-header encodings and gearbox geometry.
package eth_phy_10g_pkg;

  localparam logic [1:0] SYNC_DATA       = 2'b10;
  localparam logic [1:0] SYNC_CTRL       = 2'b01;
  localparam logic [5:0] GEARBOX_SEQ_MAX = 6'd32;
  localparam int         BLOCK_WIDTH     = 66;

endpackage

// File: rtl/eth_phy_10g_hdr_check.sv
// Sync-header monitor: flags headers that are neither data nor control and keeps a saturating tally.
module eth_phy_10g_hdr_check
  import eth_phy_10g_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 check_en,
  input  logic [1:0]           hdr,
  output logic                 hdr_error,
  output logic [CNT_WIDTH-1:0] hdr_error_count
);

  logic                 bad_s;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Bad-header detect and saturating increment.
  always_comb begin
    bad_s = check_en && (hdr != SYNC_DATA) && (hdr != SYNC_CTRL);
    err_d = bad_s;
    if (bad_s && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Error pulse and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
      cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign hdr_error       = err_q;
  assign hdr_error_count = cnt_q;

endmodule

// File: rtl/eth_phy_10g_tx_gearbox.sv
// 64b/66b to 64-bit TX gearbox: packs 32 blocks into 33 output words and pauses upstream
// once per period so the fixed-width transceiver sees a gap-free bit stream.
module eth_phy_10g_tx_gearbox
  import eth_phy_10g_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int HDR_WIDTH     = 2,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    serdes_tx_data,
  input  logic [HDR_WIDTH-1:0]     serdes_tx_hdr,
  output logic                     serdes_tx_pause,
  output logic [DATA_WIDTH-1:0]    gearbox_tx_data,
  output logic                     gearbox_tx_valid,
  output logic                     tx_hdr_error,
  output logic [ERR_CNT_WIDTH-1:0] tx_hdr_error_count
);

  if (DATA_WIDTH != 64) begin : g_bad_data_width
    $error("eth_phy_10g_tx_gearbox: DATA_WIDTH must be 64");
  end
  if (HDR_WIDTH != 2) begin : g_bad_hdr_width
    $error("eth_phy_10g_tx_gearbox: HDR_WIDTH must be 2");
  end

  localparam int SHIFT_WIDTH = 2 * DATA_WIDTH;

  logic [5:0]             seq_q, seq_d;
  logic [DATA_WIDTH-1:0]  residual_q, residual_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   accept_s;
  logic [SHIFT_WIDTH-1:0] shifted_s, combined_s;

  assign accept_s        = (seq_q != GEARBOX_SEQ_MAX);
  assign serdes_tx_pause = ~accept_s;

  // The residual always holds exactly 2*seq bits LSB-aligned, so the new block is shifted
  // above it and OR-ed in; the low word goes out and the high word becomes the new residual.
  always_comb begin
    shifted_s  = {{(SHIFT_WIDTH-BLOCK_WIDTH){1'b0}}, serdes_tx_data, serdes_tx_hdr}
                 << {seq_q, 1'b0};
    combined_s = shifted_s | {{DATA_WIDTH{1'b0}}, residual_q};
    valid_d    = 1'b1;
    if (accept_s) begin
      data_d     = combined_s[DATA_WIDTH-1:0];
      residual_d = combined_s[SHIFT_WIDTH-1:DATA_WIDTH];
      seq_d      = seq_q + 6'd1;
    end else begin
      data_d     = residual_q;
      residual_d = {DATA_WIDTH{1'b0}};
      seq_d      = 6'd0;
    end
  end

  // Sequence, residual and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q      <= 6'd0;
      residual_q <= {DATA_WIDTH{1'b0}};
      data_q     <= {DATA_WIDTH{1'b0}};
      valid_q    <= 1'b0;
    end else begin
      seq_q      <= seq_d;
      residual_q <= residual_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  assign gearbox_tx_data  = data_q;
  assign gearbox_tx_valid = valid_q;

  eth_phy_10g_hdr_check #(
    .CNT_WIDTH (ERR_CNT_WIDTH)
  ) u_hdr_check (
    .clk             (clk),
    .rst             (rst),
    .check_en        (accept_s),
    .hdr             (serdes_tx_hdr),
    .hdr_error       (tx_hdr_error),
    .hdr_error_count (tx_hdr_error_count)
  );

endmodule
